color_manager: RTL and testbench
================================

Name: color_manager

Overview:
- Receives 2-byte colour-configuration commands from a UART RX FIFO.
- Forwards each command as a configuration write over a valid/ready bus.
- Keeps a local 4-entry quadrant colour table.
- Drives the VGA pixel colour from that table, selecting the quadrant from HSync/VSync and the split enables. Sits between the UART receiver FIFO and the config/VGA output stage.

Parameters:
UART_DATA_WIDTH, 8, RX byte width
C_ADDR_WIDTH, 2, config address width (quadrant index)
C_DATA_WIDTH, 8, config data width (colour)
CONFIG_STATUS_WIDTH, 2, FSM status width
CONFIG_NOTIFICATION_WIDTH, 4, config notification code width
CONFIG_ERROR_WIDTH, 4, error code width
VGA_NOTIFICATION_WIDTH, 4, VGA notification width
DATA_WIDTH, 8, VGA pixel colour width
TIMEOUT_CYCLES, 64, data-byte timeout (optional feature only)

Ports:
Clk  in  1  single clock, rising edge
rst_n  in  1  reset; asynchronous, ACTIVE-HIGH despite the name (1 = reset)
Empty  in  1  0 = RXD_Data holds a valid byte this cycle; each low cycle delivers exactly one byte
C_Rdy  in  1  config sink ready
RXD_Data  in  UART_DATA_WIDTH  RX byte
Vertical_Split  in  1  enable left/right split
Horizontal_Split  in  1  enable up/down split
VGA_Debugg  in  1  debug pattern select
HSync  in  1  horizontal half flag (1 = right half)
VSync  in  1  vertical half flag (1 = lower half)
C_Addr  out  C_ADDR_WIDTH  config write address
C_Data  out  C_DATA_WIDTH  config write data
C_Valid  out  1  config write valid
Config_Status  out  CONFIG_STATUS_WIDTH  FSM state
Config_Notification  out  CONFIG_NOTIFICATION_WIDTH  notification code
Config_Notification_Valid  out  1  one-cycle strobe
Config_Error  out  CONFIG_ERROR_WIDTH  error code
Error_Valid  out  1  one-cycle strobe
VGA_Notification  out  VGA_NOTIFICATION_WIDTH  VGA mode code
VGA_Notification_Valid  out  1  one-cycle strobe
Data_VGA  out  DATA_WIDTH  pixel colour

Behaviour:
- Reset (async, rst_n=1):
  - All outputs, the colour table, and the registered sync/split/debug copies are set to 0.
  - FSM goes to IDLE.
- Header byte format:
  - bits[7:6] = 2'b00 (marker).
  - bits[5:4] = quadrant address: 00 left-up, 01 right-up, 11 right-down, 10 left-down (bit4 = right, bit5 = down).
  - bits[3:0] = command; 4'hA = WRITE_COLOR.
- FSM states (Config_Status encoding):
  - IDLE (2'b00): Empty=0 with a valid header goes to WAIT_DATA and latches the address.
    - Marker != 00: error 4'h1.
    - Command != 4'hA: error 4'h2.
    - On either error, pulse Error_Valid for one cycle and stay in IDLE.
  - WAIT_DATA (2'b01): the next Empty=0 byte is the colour (any value).
    - Next cycle: C_Addr = latched address, C_Data = byte, C_Valid = 1.
    - The colour table entry is written in the same cycle.
    - Go to WRITING.
  - WRITING (2'b10): hold C_Valid, C_Addr and C_Data stable until a cycle with C_Rdy=1.
    - On that cycle the transfer completes; C_Valid is 0 the next cycle.
    - Pulse Config_Notification_Valid with Config_Notification = {2'b01, addr}.
    - Return to IDLE.
    - If C_Rdy is already 1 on the first C_Valid cycle, the transfer completes in one cycle.
  - Byte arriving (Empty=0) during WRITING: dropped; error 4'h3 (overrun) pulsed; transfer continues.
- Config_Error holds its last code until the next error. Config_Notification holds its last value.
- VGA path:
  - HSync and VSync pass through a 2-flop synchroniser (hs, vs).
  - Selected quadrant q = {Horizontal_Split & vs, Vertical_Split & hs}.
  - Both splits 0: the whole screen shows entry 00.
  - Data_VGA is registered: colour[q], or {q,q,q,q} when VGA_Debugg=1.
  - Latency: 1 cycle from synchronised sync/table change to Data_VGA.
- VGA notifications:
  - Any change of {VGA_Debugg, Horizontal_Split, Vertical_Split} vs its registered copy pulses VGA_Notification_Valid for one cycle.
  - VGA_Notification = {VGA_Debugg, Horizontal_Split, Vertical_Split, 1'b1}.
- Simultaneous table write and VGA read of the same entry: Data_VGA shows the new colour one cycle after the write.

Optional Feature:
- COLOR_MANAGER_TIMEOUT_EN defined:
  - In WAIT_DATA, a counter runs. After TIMEOUT_CYCLES cycles with no byte, pulse error 4'h4 and return to IDLE.
  - The counter clears on state entry.
- COLOR_MANAGER_TIMEOUT_EN undefined: WAIT_DATA waits indefinitely and error 4'h4 never occurs.

Decomposition:
- Package color_manager_pkg holds:
  - Width parameters.
  - State encodings.
  - Command code 4'hA.
  - Error codes 1–4.
  - Notification prefix 2'b01.
- One sub-module, color_manager_vga_out: sync synchroniser, quadrant select, debug mux, VGA notification.

Test Plan:
- Reset then bytes 8'h0A, 8'h5A, C_Rdy=1 -> C_Valid=1, C_Addr=00, C_Data=8'h5A for 1 cycle; notification 4'b0100.
- Bytes 8'h1A, 8'h5F with C_Rdy=0 for 10 cycles -> C_Valid held with 01/8'h5F; completes on the first C_Rdy=1 cycle; notification 4'b0101.
- Write 3A/50 and 2A/00, set both splits; HSync=1, VSync=1 -> Data_VGA=8'h50; HSync=0, VSync=1 -> 8'h00; HSync=1, VSync=0 -> 8'h5F.
- Header 8'h8A -> Error_Valid pulse, Config_Error=1; header 8'h0B -> Config_Error=2; no C_Valid in either case.
- Byte arrives during WRITING -> Config_Error=3; toggle VGA_Debugg -> VGA_Notification_Valid pulse with 4'b1001; Data_VGA={q,q,q,q}.
- With COLOR_MANAGER_TIMEOUT_EN: header only, wait 64 cycles -> Config_Error=4; FSM back in IDLE.

Source files
------------

// File: rtl/color_manager_pkg.sv
// Shared widths, FSM encodings and command/status codes for color_manager.
// The optional data-byte timeout is enabled by defining COLOR_MANAGER_TIMEOUT_EN.
package color_manager_pkg;

   localparam int UART_DATA_WIDTH           = 8;
   localparam int C_ADDR_WIDTH              = 2;
   localparam int C_DATA_WIDTH              = 8;
   localparam int CONFIG_STATUS_WIDTH       = 2;
   localparam int CONFIG_NOTIFICATION_WIDTH = 4;
   localparam int CONFIG_ERROR_WIDTH        = 4;
   localparam int VGA_NOTIFICATION_WIDTH    = 4;
   localparam int DATA_WIDTH                = 8;
   localparam int TIMEOUT_CYCLES            = 64;

   typedef enum logic [CONFIG_STATUS_WIDTH-1:0] {
      ST_IDLE      = 2'b00,
      ST_WAIT_DATA = 2'b01,
      ST_WRITING   = 2'b10
   } state_t;

   localparam logic [1:0] HDR_MARKER      = 2'b00;
   localparam logic [3:0] CMD_WRITE_COLOR = 4'hA;
   localparam logic [1:0] NOTIF_PREFIX    = 2'b01;

   localparam logic [CONFIG_ERROR_WIDTH-1:0] ERR_MARKER  = 4'h1;
   localparam logic [CONFIG_ERROR_WIDTH-1:0] ERR_COMMAND = 4'h2;
   localparam logic [CONFIG_ERROR_WIDTH-1:0] ERR_OVERRUN = 4'h3;
   localparam logic [CONFIG_ERROR_WIDTH-1:0] ERR_TIMEOUT = 4'h4;

endpackage

// File: rtl/color_manager_vga_out.sv
// VGA output stage: sync synchroniser, quadrant select, debug pattern mux and
// mode-change notification.
module color_manager_vga_out
   import color_manager_pkg::*;
(
   input  logic                                  Clk,
   input  logic                                  rst_n,
   input  logic                                  HSync,
   input  logic                                  VSync,
   input  logic                                  Vertical_Split,
   input  logic                                  Horizontal_Split,
   input  logic                                  VGA_Debugg,
   input  logic [3:0][DATA_WIDTH-1:0]            color_tbl,
   output logic [DATA_WIDTH-1:0]                 Data_VGA,
   output logic [VGA_NOTIFICATION_WIDTH-1:0]     VGA_Notification,
   output logic                                  VGA_Notification_Valid
);

   logic       hs_meta_r;
   logic       hs_r;
   logic       vs_meta_r;
   logic       vs_r;
   logic [2:0] mode_r;
   logic [2:0] mode_s;
   logic [1:0] q_s;

   // Quadrant select from synchronised syncs gated by the split enables
   always_comb begin
      q_s    = {Horizontal_Split & vs_r, Vertical_Split & hs_r};
      mode_s = {VGA_Debugg, Horizontal_Split, Vertical_Split};
   end

   // Synchroniser, registered pixel colour and mode-change strobe
   always_ff @(posedge Clk or posedge rst_n) begin
      if (rst_n) begin
         hs_meta_r              <= 1'b0;
         hs_r                   <= 1'b0;
         vs_meta_r              <= 1'b0;
         vs_r                   <= 1'b0;
         mode_r                 <= 3'b000;
         Data_VGA               <= '0;
         VGA_Notification       <= '0;
         VGA_Notification_Valid <= 1'b0;
      end else begin
         hs_meta_r <= HSync;
         hs_r      <= hs_meta_r;
         vs_meta_r <= VSync;
         vs_r      <= vs_meta_r;
         mode_r    <= mode_s;
         if (VGA_Debugg) begin
            Data_VGA <= {4{q_s}};
         end else begin
            Data_VGA <= color_tbl[q_s];
         end
         if (mode_s != mode_r) begin
            VGA_Notification_Valid <= 1'b1;
            VGA_Notification       <= {mode_s, 1'b1};
         end else begin
            VGA_Notification_Valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/color_manager.sv
// Two-byte UART colour command decoder, config bus writer and quadrant colour table.
// Define COLOR_MANAGER_TIMEOUT_EN to abandon a command whose colour byte never arrives.
module color_manager
   import color_manager_pkg::*;
(
   input  logic                                  Clk,
   input  logic                                  rst_n,
   input  logic                                  Empty,
   input  logic                                  C_Rdy,
   input  logic [UART_DATA_WIDTH-1:0]            RXD_Data,
   input  logic                                  Vertical_Split,
   input  logic                                  Horizontal_Split,
   input  logic                                  VGA_Debugg,
   input  logic                                  HSync,
   input  logic                                  VSync,
   output logic [C_ADDR_WIDTH-1:0]               C_Addr,
   output logic [C_DATA_WIDTH-1:0]               C_Data,
   output logic                                  C_Valid,
   output logic [CONFIG_STATUS_WIDTH-1:0]        Config_Status,
   output logic [CONFIG_NOTIFICATION_WIDTH-1:0]  Config_Notification,
   output logic                                  Config_Notification_Valid,
   output logic [CONFIG_ERROR_WIDTH-1:0]         Config_Error,
   output logic                                  Error_Valid,
   output logic [VGA_NOTIFICATION_WIDTH-1:0]     VGA_Notification,
   output logic                                  VGA_Notification_Valid,
   output logic [DATA_WIDTH-1:0]                 Data_VGA
);

   state_t                         state_r;
   logic [C_ADDR_WIDTH-1:0]        addr_r;
   logic [3:0][DATA_WIDTH-1:0]     color_tbl_r;
`ifdef COLOR_MANAGER_TIMEOUT_EN
   localparam int TO_CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_CNT_W-1:0]            timeout_cnt_r;
`endif

   assign Config_Status = state_r;

   // Command FSM: header decode, colour capture, config handshake and error strobes
   always_ff @(posedge Clk or posedge rst_n) begin
      if (rst_n) begin
         state_r                   <= ST_IDLE;
         addr_r                    <= '0;
         color_tbl_r               <= '0;
         C_Addr                    <= '0;
         C_Data                    <= '0;
         C_Valid                   <= 1'b0;
         Config_Notification       <= '0;
         Config_Notification_Valid <= 1'b0;
         Config_Error              <= '0;
         Error_Valid               <= 1'b0;
`ifdef COLOR_MANAGER_TIMEOUT_EN
         timeout_cnt_r             <= '0;
`endif
      end else begin
         Config_Notification_Valid <= 1'b0;
         Error_Valid               <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!Empty) begin
                  if (RXD_Data[7:6] != HDR_MARKER) begin
                     Error_Valid  <= 1'b1;
                     Config_Error <= ERR_MARKER;
                  end else if (RXD_Data[3:0] != CMD_WRITE_COLOR) begin
                     Error_Valid  <= 1'b1;
                     Config_Error <= ERR_COMMAND;
                  end else begin
                     addr_r  <= RXD_Data[5:4];
                     state_r <= ST_WAIT_DATA;
`ifdef COLOR_MANAGER_TIMEOUT_EN
                     timeout_cnt_r <= '0;
`endif
                  end
               end
            end
            ST_WAIT_DATA: begin
               if (!Empty) begin
                  C_Addr              <= addr_r;
                  C_Data              <= RXD_Data;
                  C_Valid             <= 1'b1;
                  color_tbl_r[addr_r] <= RXD_Data;
                  state_r             <= ST_WRITING;
               end
`ifdef COLOR_MANAGER_TIMEOUT_EN
               else if (timeout_cnt_r == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  Error_Valid  <= 1'b1;
                  Config_Error <= ERR_TIMEOUT;
                  state_r      <= ST_IDLE;
               end else begin
                  timeout_cnt_r <= timeout_cnt_r + TO_CNT_W'(1);
               end
`endif
            end
            ST_WRITING: begin
               // Bytes arriving mid-transfer are dropped, not queued
               if (!Empty) begin
                  Error_Valid  <= 1'b1;
                  Config_Error <= ERR_OVERRUN;
               end
               if (C_Rdy) begin
                  C_Valid                   <= 1'b0;
                  Config_Notification       <= {NOTIF_PREFIX, addr_r};
                  Config_Notification_Valid <= 1'b1;
                  state_r                   <= ST_IDLE;
               end
            end
            default: begin
               C_Valid <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   color_manager_vga_out u_vga_out (
      .Clk                    (Clk),
      .rst_n                  (rst_n),
      .HSync                  (HSync),
      .VSync                  (VSync),
      .Vertical_Split         (Vertical_Split),
      .Horizontal_Split       (Horizontal_Split),
      .VGA_Debugg             (VGA_Debugg),
      .color_tbl              (color_tbl_r),
      .Data_VGA               (Data_VGA),
      .VGA_Notification       (VGA_Notification),
      .VGA_Notification_Valid (VGA_Notification_Valid)
   );

endmodule

// File: tb/tb_color_manager.sv
// Directed, table-driven bench for color_manager: config path vectors plus
// hand-written VGA, debug, simultaneous-write and timeout sequences.
module tb_color_manager;

   logic       Clk;
   logic       rst_n;
   logic       Empty;
   logic       C_Rdy;
   logic [7:0] RXD_Data;
   logic       Vertical_Split;
   logic       Horizontal_Split;
   logic       VGA_Debugg;
   logic       HSync;
   logic       VSync;
   logic [1:0] C_Addr;
   logic [7:0] C_Data;
   logic       C_Valid;
   logic [1:0] Config_Status;
   logic [3:0] Config_Notification;
   logic       Config_Notification_Valid;
   logic [3:0] Config_Error;
   logic       Error_Valid;
   logic [3:0] VGA_Notification;
   logic       VGA_Notification_Valid;
   logic [7:0] Data_VGA;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       empty;
      logic [7:0] rxd;
      logic       rdy;
      int         reps;
      logic [1:0] st;
      logic       cv;
      logic [1:0] ca;
      logic [7:0] cd;
      logic       nv;
      logic [3:0] nt;
      logic       ev;
      logic [3:0] er;
   } vec_t;

   vec_t vecs[22];

   color_manager dut (
      .Clk                       (Clk),
      .rst_n                     (rst_n),
      .Empty                     (Empty),
      .C_Rdy                     (C_Rdy),
      .RXD_Data                  (RXD_Data),
      .Vertical_Split            (Vertical_Split),
      .Horizontal_Split          (Horizontal_Split),
      .VGA_Debugg                (VGA_Debugg),
      .HSync                     (HSync),
      .VSync                     (VSync),
      .C_Addr                    (C_Addr),
      .C_Data                    (C_Data),
      .C_Valid                   (C_Valid),
      .Config_Status             (Config_Status),
      .Config_Notification       (Config_Notification),
      .Config_Notification_Valid (Config_Notification_Valid),
      .Config_Error              (Config_Error),
      .Error_Valid               (Error_Valid),
      .VGA_Notification          (VGA_Notification),
      .VGA_Notification_Valid    (VGA_Notification_Valid),
      .Data_VGA                  (Data_VGA)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      //          empty  rxd    rdy  reps st     cv    ca     cd     nv    nt    ev    er
      vecs[0]  = '{1'b0, 8'h0A, 1'b1, 1,  2'b01, 1'b0, 2'd0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0};
      vecs[1]  = '{1'b0, 8'h5A, 1'b1, 1,  2'b10, 1'b1, 2'd0, 8'h5A, 1'b0, 4'h0, 1'b0, 4'h0};
      vecs[2]  = '{1'b1, 8'h00, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h4, 1'b0, 4'h0};
      vecs[3]  = '{1'b1, 8'h00, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b0, 4'h4, 1'b0, 4'h0};
      vecs[4]  = '{1'b0, 8'h1A, 1'b0, 1,  2'b01, 1'b0, 2'd0, 8'h00, 1'b0, 4'h4, 1'b0, 4'h0};
      vecs[5]  = '{1'b0, 8'h5F, 1'b0, 1,  2'b10, 1'b1, 2'd1, 8'h5F, 1'b0, 4'h4, 1'b0, 4'h0};
      vecs[6]  = '{1'b1, 8'h00, 1'b0, 10, 2'b10, 1'b1, 2'd1, 8'h5F, 1'b0, 4'h4, 1'b0, 4'h0};
      vecs[7]  = '{1'b1, 8'h00, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h5, 1'b0, 4'h0};
      vecs[8]  = '{1'b0, 8'h8A, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b0, 4'h5, 1'b1, 4'h1};
      vecs[9]  = '{1'b1, 8'h00, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b0, 4'h5, 1'b0, 4'h1};
      vecs[10] = '{1'b0, 8'h0B, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b0, 4'h5, 1'b1, 4'h2};
      vecs[11] = '{1'b1, 8'h00, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b0, 4'h5, 1'b0, 4'h2};
      vecs[12] = '{1'b0, 8'h3A, 1'b1, 1,  2'b01, 1'b0, 2'd0, 8'h00, 1'b0, 4'h5, 1'b0, 4'h2};
      vecs[13] = '{1'b0, 8'h50, 1'b1, 1,  2'b10, 1'b1, 2'd3, 8'h50, 1'b0, 4'h5, 1'b0, 4'h2};
      vecs[14] = '{1'b1, 8'h00, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h7, 1'b0, 4'h2};
      vecs[15] = '{1'b0, 8'h2A, 1'b1, 1,  2'b01, 1'b0, 2'd0, 8'h00, 1'b0, 4'h7, 1'b0, 4'h2};
      vecs[16] = '{1'b0, 8'h00, 1'b1, 1,  2'b10, 1'b1, 2'd2, 8'h00, 1'b0, 4'h7, 1'b0, 4'h2};
      vecs[17] = '{1'b1, 8'h00, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h6, 1'b0, 4'h2};
      vecs[18] = '{1'b0, 8'h0A, 1'b0, 1,  2'b01, 1'b0, 2'd0, 8'h00, 1'b0, 4'h6, 1'b0, 4'h2};
      vecs[19] = '{1'b0, 8'h77, 1'b0, 1,  2'b10, 1'b1, 2'd0, 8'h77, 1'b0, 4'h6, 1'b0, 4'h2};
      vecs[20] = '{1'b0, 8'h12, 1'b0, 1,  2'b10, 1'b1, 2'd0, 8'h77, 1'b0, 4'h6, 1'b1, 4'h3};
      vecs[21] = '{1'b1, 8'h00, 1'b1, 1,  2'b00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h4, 1'b0, 4'h3};

      rst_n = 1'b1; Empty = 1'b1; C_Rdy = 1'b1; RXD_Data = 8'h00;
      Vertical_Split = 1'b0; Horizontal_Split = 1'b0; VGA_Debugg = 1'b0;
      HSync = 1'b0; VSync = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      chk("rst_status", {6'd0, Config_Status}, 8'h00);
      chk("rst_cvalid", {7'd0, C_Valid}, 8'h00);
      chk("rst_error", {4'd0, Config_Error}, 8'h00);
      chk("rst_data_vga", Data_VGA, 8'h00);
      chk("rst_vga_nv", {7'd0, VGA_Notification_Valid}, 8'h00);

      // Config path vectors: table afterwards is {0:77, 1:5F, 2:00, 3:50}
      for (int i = 0; i < 22; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            Empty = vecs[i].empty; RXD_Data = vecs[i].rxd; C_Rdy = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_status", i), {6'd0, Config_Status}, {6'd0, vecs[i].st});
            chk($sformatf("v%0d_cvalid", i), {7'd0, C_Valid}, {7'd0, vecs[i].cv});
            if (vecs[i].cv) begin
               chk($sformatf("v%0d_caddr", i), {6'd0, C_Addr}, {6'd0, vecs[i].ca});
               chk($sformatf("v%0d_cdata", i), C_Data, vecs[i].cd);
            end
            chk($sformatf("v%0d_notif_v", i), {7'd0, Config_Notification_Valid}, {7'd0, vecs[i].nv});
            chk($sformatf("v%0d_notif", i), {4'd0, Config_Notification}, {4'd0, vecs[i].nt});
            chk($sformatf("v%0d_err_v", i), {7'd0, Error_Valid}, {7'd0, vecs[i].ev});
            chk($sformatf("v%0d_err", i), {4'd0, Config_Error}, {4'd0, vecs[i].er});
         end
      end
      Empty = 1'b1; C_Rdy = 1'b1;

      // Splits off: whole screen shows entry 0 regardless of syncs
      HSync = 1'b1; VSync = 1'b1;
      repeat (4) step();
      chk("vga_nosplit", Data_VGA, 8'h77);
      Vertical_Split = 1'b1; Horizontal_Split = 1'b1;
      step();
      chk("vga_split_nv", {7'd0, VGA_Notification_Valid}, 8'h01);
      chk("vga_split_nt", {4'd0, VGA_Notification}, 8'h07);
      chk("vga_q3", Data_VGA, 8'h50);
      step();
      chk("vga_split_nv_clr", {7'd0, VGA_Notification_Valid}, 8'h00);
      HSync = 1'b0;
      repeat (3) step();
      chk("vga_q2", Data_VGA, 8'h00);
      HSync = 1'b1; VSync = 1'b0;
      repeat (3) step();
      chk("vga_q1", Data_VGA, 8'h5F);

      // Write to the entry being displayed: new colour one cycle after the write
      Empty = 1'b0; RXD_Data = 8'h1A;
      step();
      RXD_Data = 8'hAB;
      step();
      Empty = 1'b1;
      chk("wr_rd_old", Data_VGA, 8'h5F);
      step();
      chk("wr_rd_new", Data_VGA, 8'hAB);
      chk("wr_rd_status", {6'd0, Config_Status}, 8'h00);

      // Debug pattern and mode notifications
      Vertical_Split = 1'b0; Horizontal_Split = 1'b0;
      step();
      chk("nosplit_nt", {4'd0, VGA_Notification}, 8'h01);
      step();
      VGA_Debugg = 1'b1;
      step();
      chk("dbg_nv", {7'd0, VGA_Notification_Valid}, 8'h01);
      chk("dbg_nt", {4'd0, VGA_Notification}, 8'h09);
      chk("dbg_q0", Data_VGA, 8'h00);
      step();
      chk("dbg_nv_clr", {7'd0, VGA_Notification_Valid}, 8'h00);
      Vertical_Split = 1'b1; Horizontal_Split = 1'b1;
      step();
      chk("dbg_split_nt", {4'd0, VGA_Notification}, 8'h0F);
      chk("dbg_q1", Data_VGA, 8'h55);

      // Colour byte never arrives
      Empty = 1'b0; RXD_Data = 8'h0A;
      step();
      Empty = 1'b1;
`ifdef COLOR_MANAGER_TIMEOUT_EN
      repeat (63) step();
      chk("to_before_status", {6'd0, Config_Status}, 8'h01);
      chk("to_before_ev", {7'd0, Error_Valid}, 8'h00);
      step();
      chk("to_ev", {7'd0, Error_Valid}, 8'h01);
      chk("to_err", {4'd0, Config_Error}, 8'h04);
      chk("to_status", {6'd0, Config_Status}, 8'h00);
`else
      repeat (100) step();
      chk("noto_status", {6'd0, Config_Status}, 8'h01);
      chk("noto_err", {4'd0, Config_Error}, 8'h03);
      Empty = 1'b0; RXD_Data = 8'h11;
      step();
      Empty = 1'b1;
      chk("noto_late_cv", {7'd0, C_Valid}, 8'h01);
      step();
      chk("noto_done", {6'd0, Config_Status}, 8'h00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
